// File: rtl/uart_rx_param.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Oversampling UART receiver with 3-sample majority vote,
//               glitch-rejecting start detection, sticky error flags and a
//               first-word-fall-through receive FIFO.
//               Optional break detection is enabled by `define UART_RX_BREAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 fifo_full,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 break_det
);

    localparam int c_SW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS + 1);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;

    localparam logic [c_SW-1:0] c_MID   = c_SW'(OVERSAMPLE / 2);
    localparam logic [c_SW-1:0] c_MIDM1 = c_SW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SW-1:0] c_MIDP1 = c_SW'(OVERSAMPLE / 2 + 1);
    localparam logic [c_SW-1:0] c_LAST  = c_SW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_DLAST = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_SLAST = c_BW'(STOP_BITS - 1);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [c_SW-1:0]       r_samp;
    logic [c_SW-1:0]       w_samp_nx;
    logic [c_BW-1:0]       r_bit;
    logic [c_BW-1:0]       w_bit_nx;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic                  r_v0;
    logic                  r_v1;
    logic                  w_vote;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bad;
    logic                  r_stop_bad;
    logic                  w_shift_en;
    logic                  w_par_en;
    logic                  w_stop_en;
    logic                  w_done;
    logic                  w_is_break;
    logic                  w_par_exp;
    logic                  w_frame_bad;
    logic                  w_good;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;

    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]       r_wp;
    logic [c_PW-1:0]       r_rp;
    logic [c_CW-1:0]       r_cnt;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_ovr;
    logic                  r_brk;

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // The third vote sample is the live synchronised line at MID+1.
    assign w_vote    = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
    assign w_par_exp = (PARITY == 2) ? ~(^r_shift) : (^r_shift);

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_samp  <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_samp  <= w_samp_nx;
            r_bit   <= w_bit_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_samp_nx  = r_samp;
        w_bit_nx   = r_bit;
        w_shift_en = 1'b0;
        w_par_en   = 1'b0;
        w_stop_en  = 1'b0;
        w_done     = 1'b0;
        if (clken) begin
            w_samp_nx = r_samp + 1'b1;
            case (r_state)
                S_IDLE: begin
                    w_samp_nx = '0;
                    if (!r_rx_s) w_state_nx = S_START;
                end
                S_START: begin
                    if (r_samp == c_MID && r_rx_s) begin
                        w_state_nx = S_IDLE;
                        w_samp_nx  = '0;
                    end else if (r_samp == c_LAST) begin
                        w_state_nx = S_DATA;
                        w_samp_nx  = '0;
                        w_bit_nx   = '0;
                    end
                end
                S_DATA: begin
                    w_shift_en = (r_samp == c_MIDP1);
                    if (r_samp == c_LAST) begin
                        w_samp_nx = '0;
                        if (r_bit == c_DLAST) begin
                            w_bit_nx   = '0;
                            w_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_nx = r_bit + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    w_par_en = (r_samp == c_MIDP1);
                    if (r_samp == c_LAST) begin
                        w_samp_nx  = '0;
                        w_bit_nx   = '0;
                        w_state_nx = S_STOP;
                    end
                end
                S_STOP: begin
                    if (r_samp == c_MIDP1) begin
                        w_stop_en = 1'b1;
                        // Leave on the last vote so a short stop bit still lets the next start be seen.
                        if (r_bit == c_SLAST) begin
                            w_done     = 1'b1;
                            w_samp_nx  = '0;
                            w_state_nx = w_is_break ? S_HOLD : S_IDLE;
                        end
                    end else if (r_samp == c_LAST) begin
                        w_samp_nx = '0;
                        w_bit_nx  = r_bit + 1'b1;
                    end
                end
                S_HOLD: begin
                    w_samp_nx = '0;
                    if (r_rx_s) w_state_nx = S_IDLE;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_samp_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            r_v0       <= 1'b1;
            r_v1       <= 1'b1;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            if (clken && r_samp == c_MIDM1) r_v0 <= r_rx_s;
            if (clken && r_samp == c_MID)   r_v1 <= r_rx_s;
            if (w_shift_en) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (w_par_en)   r_par_bad <= (w_vote != w_par_exp);
            if (w_stop_en)  r_stop_bad <= r_stop_bad | ~w_vote;
            if (r_state == S_IDLE) begin
                r_par_bad  <= 1'b0;
                r_stop_bad <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_EN
    logic r_par_bit;
    logic r_stop0_low;
    logic w_first_low;

    assign w_first_low = (r_bit == '0) ? ~w_vote : r_stop0_low;
    assign w_is_break  = (r_shift == '0) && !r_par_bit && w_first_low;

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            r_par_bit   <= 1'b0;
            r_stop0_low <= 1'b0;
        end else begin
            if (r_state == S_IDLE) r_par_bit <= 1'b0;
            else if (w_par_en)     r_par_bit <= w_vote;
            if (w_stop_en && r_bit == '0) r_stop0_low <= ~w_vote;
        end
    end
`else
    assign w_is_break = 1'b0;
`endif

    assign w_frame_bad = r_stop_bad | ~w_vote;
    assign w_good      = w_done & ~w_frame_bad & ~w_is_break;
    assign w_full      = (r_cnt == c_DEPTH);
    assign w_pop       = rd_en & valid;
    assign w_push      = w_good & (~w_full | w_pop);

    always_ff @(posedge clk_50m) begin
        if (w_push) r_mem[r_wp] <= r_shift;
    end

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // A set in the same cycle as err_clr wins.
    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            r_brk  <= 1'b0;
        end else begin
            r_perr <= (r_perr & ~err_clr) | (w_good & r_par_bad);
            r_ferr <= (r_ferr & ~err_clr) | (w_done & w_frame_bad & ~w_is_break);
            r_ovr  <= (r_ovr  & ~err_clr) | (w_good & w_full & ~rd_en);
            r_brk  <= w_done & w_is_break;
        end
    end

    assign valid      = (r_cnt != '0);
    assign fifo_full  = w_full;
    assign data       = valid ? r_mem[r_rp] : '0;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign break_det  = r_brk;

endmodule
`default_nettype wire
